// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM port emulator.
// Widths, FSM state encoding, default pass length, pointer-wrap helper.
package sdram_pkg;

    localparam int DATA_W        = 16;
    localparam int ADDR_W        = 12;
    localparam int CNT_W         = 13;
    localparam int INIT_W        = 14;
    localparam int DATA_LENG_DEF = 2048;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_READY = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // Advance a pointer, wrapping back to 0 after the last word of a pass.
    function automatic logic [ADDR_W-1:0] ptr_next(
        input logic [ADDR_W-1:0] p,
        input logic [ADDR_W-1:0] last
    );
        return (p == last) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/sdram_emu_ram.sv
// Storage array: simple dual-port 4096x16, synchronous read, write-first.
// Ports: clk_50m; i_we/i_waddr/i_wdata write; i_re/i_raddr read; o_q data.
module sdram_emu_ram
    import sdram_pkg::*;
(
    input  logic              clk_50m,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_q;

    // Contents are deliberately not reset; validity lives in wr_count.
    // o_q holds while i_re is low.
    always_ff @(posedge clk_50m) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            if (i_we && (i_waddr == i_raddr)) begin
                r_q <= i_wdata;
            end else begin
                r_q <= r_mem[i_raddr];
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sdram_port_emu.sv
// Behavioural SDRAM port: init delay, one write pass, looping reads.
// Ports: clk_50m, rst_n; wr_en/wr_data; rd_en/rd_data; err_inject;
//        sdram_init_done, wr_overflow, rd_underflow, wr_count.
module sdram_port_emu
    import sdram_pkg::*;
#(
    parameter int DATA_LENG   = DATA_LENG_DEF,
    parameter int INIT_CYCLES = 10000
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    input  logic              err_inject,
    output logic              sdram_init_done,
    output logic              wr_overflow,
    output logic              rd_underflow,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LEN_M1    = CNT_W'(DATA_LENG - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DATA_LENG - 1);

    state_t              r_state;
    logic [INIT_W-1:0]   r_init_cnt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]    r_wr_count;
    logic                r_init_done;
    logic                r_wr_overflow;
    logic                r_rd_underflow;
    logic                r_err_arm;
    logic                r_rd_zero;
    logic                r_rd_flip;

    logic                w_wr_do;
    logic                w_rd_do;
    logic                w_wr_hit;
    logic                w_rd_empty;
    logic                w_flip;
    logic [DATA_W-1:0]   w_ram_q;

    assign w_wr_do  = (r_state == S_READY) && wr_en;
    assign w_rd_do  = (r_state != S_INIT) && rd_en;
    assign w_wr_hit = w_wr_do && (r_wr_ptr == r_rd_ptr);

    // A word being written this cycle at the read address is valid
    // (write-first), even though wr_count has not caught up yet.
    assign w_rd_empty = ({1'b0, r_rd_ptr} >= r_wr_count) && !w_wr_hit;

    // A pulse coincident with a read corrupts that same read.
    assign w_flip = r_err_arm | err_inject;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_INIT;
            r_init_cnt     <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_wr_count     <= '0;
            r_init_done    <= 1'b0;
            r_wr_overflow  <= 1'b0;
            r_rd_underflow <= 1'b0;
            r_err_arm      <= 1'b0;
            r_rd_zero      <= 1'b1;
            r_rd_flip      <= 1'b0;
        end else begin
            // One edge after leaving S_INIT; sticky until reset.
            r_init_done <= r_init_done | (r_state != S_INIT);

            unique case (r_state)
                S_INIT: begin
                    if (r_init_cnt == INIT_LAST) begin
                        r_state <= S_READY;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (wr_en) begin
                        r_wr_ptr   <= r_wr_ptr + 1'b1;
                        r_wr_count <= r_wr_count + 1'b1;
                        if (r_wr_count == LEN_M1) begin
                            r_state <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (wr_en) begin
                        r_wr_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase

            if (w_rd_do) begin
                r_rd_ptr  <= ptr_next(r_rd_ptr, PTR_LAST);
                r_rd_zero <= w_rd_empty;
                r_rd_flip <= w_flip;
                r_err_arm <= 1'b0;
                if (w_rd_empty) begin
                    r_rd_underflow <= 1'b1;
                end
            end else if (err_inject) begin
                r_err_arm <= 1'b1;
            end
        end
    end

    sdram_emu_ram u_ram (
        .clk_50m (clk_50m),
        .i_we    (w_wr_do),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data),
        .i_re    (w_rd_do),
        .i_raddr (r_rd_ptr),
        .o_q     (w_ram_q)
    );

    // The RAM output register is the read stage; the zero/flip qualifiers
    // were captured alongside it, so all three change on the same edge.
    assign rd_data = r_rd_zero ? '0
                   : (w_ram_q ^ {{(DATA_W-1){1'b0}}, r_rd_flip});

    assign sdram_init_done = r_init_done;
    assign wr_overflow     = r_wr_overflow;
    assign rd_underflow    = r_rd_underflow;
    assign wr_count        = r_wr_count;

endmodule

// File: tb/tb_sdram_port_emu.sv
// Directed self-checking bench for sdram_port_emu.
// Init latency, full pass, wrap, overflow, underflow, error inject, reset.
module tb_sdram_port_emu;

    logic        clk_50m;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        err_inject;
    logic        sdram_init_done;
    logic        wr_overflow;
    logic        rd_underflow;
    logic [12:0] wr_count;

    int n_chk;
    int n_err;
    int want;

    sdram_port_emu #(
        .DATA_LENG   (2048),
        .INIT_CYCLES (16)
    ) dut (
        .clk_50m         (clk_50m),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .err_inject      (err_inject),
        .sdram_init_done (sdram_init_done),
        .wr_overflow     (wr_overflow),
        .rd_underflow    (rd_underflow),
        .wr_count        (wr_count)
    );

    initial begin
        clk_50m = 1'b0;
        forever #10 clk_50m = ~clk_50m;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reset, check reset values, release on a falling edge and count
    // rising edges until init_done, strobing wr/rd early during init.
    task automatic do_init();
        int lat;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        err_inject = 1'b0;
        wr_data    = 16'h0000;
        repeat (2) @(negedge clk_50m);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_done", sdram_init_done, 0);
        chk("rst_wcnt", wr_count, 0);
        chk("rst_ovf", wr_overflow, 0);
        chk("rst_unf", rd_underflow, 0);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            wr_en   = (k <= 10);
            rd_en   = (k <= 10);
            wr_data = 16'hAAAA;
            @(negedge clk_50m);
            if (sdram_init_done) begin
                lat = k;
                break;
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("init_lat", lat, 17);
        chk("init_wcnt", wr_count, 0);
        chk("init_unf", rd_underflow, 0);
        chk("init_rd", rd_data, 0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        do_init();

        // Full pass 1..2048.
        for (int i = 1; i <= 2048; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'(i);
            @(negedge clk_50m);
        end
        wr_en = 1'b0;
        chk("full_wcnt", wr_count, 2048);

        // Continuous reads across the wrap point.
        rd_en = 1'b1;
        for (int j = 1; j <= 2050; j++) begin
            @(negedge clk_50m);
            want = ((j - 1) % 2048) + 1;
            chk($sformatf("rd_%0d", j), rd_data, want);
        end
        rd_en = 1'b0;
        repeat (2) @(negedge clk_50m);
        chk("rd_hold", rd_data, 2);
        chk("pass_ovf", wr_overflow, 0);
        chk("pass_unf", rd_underflow, 0);

        // Error injection: armed pulse, then a coincident pulse.
        for (int v = 3; v <= 13; v++) begin
            if (v == 10) begin
                err_inject = 1'b1;
                @(negedge clk_50m);
                err_inject = 1'b0;
            end
            rd_en      = 1'b1;
            err_inject = (v == 12);
            @(negedge clk_50m);
            rd_en      = 1'b0;
            err_inject = 1'b0;
            want = (v == 10 || v == 12) ? (v ^ 1) : v;
            chk($sformatf("err_rd_%0d", v), rd_data, want);
        end

        // Overflow write must not disturb stored data.
        wr_en   = 1'b1;
        wr_data = 16'hBEEF;
        @(negedge clk_50m);
        wr_en = 1'b0;
        chk("ovf_flag", wr_overflow, 1);
        chk("ovf_wcnt", wr_count, 2048);

        rd_en = 1'b1;
        repeat (2035) @(negedge clk_50m);
        chk("ovf_last", rd_data, 2048);
        @(negedge clk_50m);
        chk("ovf_word1", rd_data, 1);
        chk("ovf_unf", rd_underflow, 0);

        // Reset in the middle of read 500.
        repeat (499) @(negedge clk_50m);
        chk("pre_rst", rd_data, 500);
        #5 rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", rd_data, 0);
        chk("mid_rst_done", sdram_init_done, 0);
        chk("mid_rst_wcnt", wr_count, 0);
        chk("mid_rst_ovf", wr_overflow, 0);
        chk("mid_rst_unf", rd_underflow, 0);
        rd_en = 1'b0;

        do_init();

        // Write-first: write and read address 0 in the same cycle.
        wr_en   = 1'b1;
        wr_data = 16'h0011;
        rd_en   = 1'b1;
        @(negedge clk_50m);
        rd_en = 1'b0;
        chk("wf_data", rd_data, 16'h0011);
        chk("wf_unf", rd_underflow, 0);
        for (int i = 2; i <= 4; i++) begin
            wr_data = 16'(i * 16'h0011);
            @(negedge clk_50m);
        end
        wr_en = 1'b0;
        chk("uf_wcnt", wr_count, 4);

        // Five more reads: three valid words, then two unwritten.
        rd_en = 1'b1;
        for (int r = 2; r <= 6; r++) begin
            @(negedge clk_50m);
            want = (r <= 4) ? r * 16'h0011 : 0;
            chk($sformatf("uf_rd_%0d", r), rd_data, want);
            chk($sformatf("uf_flag_%0d", r), rd_underflow, (r >= 5) ? 1 : 0);
        end
        rd_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
